// File: rtl/w_stage_grf.sv
// Writeback stage of the five-stage MIPS pipeline: decodes the W destination and data
// source, commits into the 32x32 register file and serves the D-stage reads with W->D bypass.
module w_stage_grf #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_w,
   input  logic [31:0] pc_w,
   input  logic [31:0] alu_w,
   input  logic [31:0] dm_w,
   input  logic [31:0] md_w,
   input  logic        b_j_w,
   input  logic [4:0]  rs_addr_d,
   input  logic [4:0]  rt_addr_d,
   output logic [31:0] rs_data_d,
   output logic [31:0] rt_data_d,
   output logic        fwd_we_w,
   output logic [4:0]  fwd_addr_w,
   output logic [31:0] fwd_data_w,
   output logic [31:0] retired_cnt
);

   typedef enum logic [2:0] {SRC_NONE, SRC_ALU, SRC_DM, SRC_MD, SRC_PC8} src_e;

   typedef struct packed {
      logic       wr;
      logic [4:0] dest;
      src_e       src;
   } dec_t;

   logic [5:0]  op, funct;
   logic [4:0]  rt, rd;
   dec_t        dec;
   logic [31:0] pc8;
   logic [31:0][31:0] rf_q, rf_d;
   logic [31:0] retired_cnt_q, retired_cnt_d;
   logic        unused_bits;

   assign op    = instr_w[31:26];
   assign funct = instr_w[5:0];
   assign rt    = instr_w[20:16];
   assign rd    = instr_w[15:11];
   assign pc8   = pc_w + 32'd8;

   // RESET_PC only documents the idle W contents; rs and shamt fields are not needed here.
   assign unused_bits = ^{RESET_PC, instr_w[25:21], instr_w[10:6]};

   always_comb begin
      dec = '{wr: 1'b0, dest: 5'd0, src: SRC_NONE};
      case (op)
         6'h00: begin
            case (funct)
               6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03:
                  dec = '{wr: 1'b1, dest: rd, src: SRC_ALU};
               6'h10, 6'h12: dec = '{wr: 1'b1, dest: rd, src: SRC_MD};
               6'h09:        dec = '{wr: 1'b1, dest: rd, src: SRC_PC8};
               default:      dec = '{wr: 1'b0, dest: 5'd0, src: SRC_NONE};
            endcase
         end
         6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h0a:
            dec = '{wr: 1'b1, dest: rt, src: SRC_ALU};
         6'h23, 6'h20, 6'h24, 6'h21, 6'h25:
            dec = '{wr: 1'b1, dest: rt, src: SRC_DM};
         6'h03: dec = '{wr: 1'b1, dest: 5'd31, src: SRC_PC8};
         6'h01: begin
            // Conditional links only write when the branch condition held.
            if ((rt == 5'h10 || rt == 5'h11) && b_j_w)
               dec = '{wr: 1'b1, dest: 5'd31, src: SRC_PC8};
         end
         default: dec = '{wr: 1'b0, dest: 5'd0, src: SRC_NONE};
      endcase
   end

   always_comb begin
      case (dec.src)
         SRC_ALU: fwd_data_w = alu_w;
         SRC_DM:  fwd_data_w = dm_w;
         SRC_MD:  fwd_data_w = md_w;
         SRC_PC8: fwd_data_w = pc8;
         default: fwd_data_w = 32'd0;
      endcase
   end

   assign fwd_we_w   = dec.wr && (dec.dest != 5'd0) && reset;
   assign fwd_addr_w = fwd_we_w ? dec.dest : 5'd0;

   always_comb begin
      rs_data_d = rf_q[rs_addr_d];
      if (rs_addr_d == 5'd0)
         rs_data_d = 32'd0;
      else if (fwd_we_w && rs_addr_d == fwd_addr_w)
         rs_data_d = fwd_data_w;
   end

   always_comb begin
      rt_data_d = rf_q[rt_addr_d];
      if (rt_addr_d == 5'd0)
         rt_data_d = 32'd0;
      else if (fwd_we_w && rt_addr_d == fwd_addr_w)
         rt_data_d = fwd_data_w;
   end

   always_comb begin
      rf_d = rf_q;
      if (fwd_we_w)
         rf_d[fwd_addr_w] = fwd_data_w;
      rf_d[0] = 32'd0;
      retired_cnt_d = retired_cnt_q + {31'd0, (instr_w != 32'd0)};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rf_q          <= '0;
         retired_cnt_q <= 32'd0;
      end else begin
         rf_q          <= rf_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign retired_cnt = retired_cnt_q;

endmodule

// File: doc/w_stage_grf.md
# w_stage_grf

Writeback-stage general register file for the five-stage MIPS pipeline. Takes the W-stage pipeline-register fields (instruction, PC, ALU result, load data, HI/LO data, link condition) and decodes the destination register and write-data source. Commits the result into a 32×32 register file and serves the two D-stage read ports with same-cycle W→D bypass. Also exports the W-stage write for the hazard/forwarding unit and keeps a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value treated as "no instruction" after reset; affects nothing but documentation of idle W contents.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets
- `instr_w`  in  32  W-stage instruction
- `pc_w`  in  32  W-stage instruction address
- `alu_w`  in  32  ALU result
- `dm_w`  in  32  load data, already extended
- `md_w`  in  32  HI/LO read result
- `b_j_w`  in  1  link condition for conditional-link branches
- `rs_addr_d`, `rt_addr_d`  in  5  D-stage read addresses
- `rs_data_d`, `rt_data_d`  out  32  D-stage read data
- `fwd_we_w`  out  1  W stage writes a nonzero register this cycle
- `fwd_addr_w`  out  5  W destination, 0 when not writing
- `fwd_data_w`  out  32  W write data
- `retired_cnt`  out  32  count of nonzero instructions that reached W

## Operation
- Decode (op = instr[31:26], funct = instr[5:0], rt = instr[20:16], rd = instr[15:11]):
  - op 0, funct in {0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x2a slt, 0x2b sltu, 0x00 sll, 0x02 srl, 0x03 sra}: dest rd, src ALU.
  - op 0, funct 0x10 mfhi / 0x12 mflo: dest rd, src MD.
  - op 0, funct 0x09 jalr: dest rd, src PC+8.
  - op in {0x08 addi, 0x09 addiu, 0x0c andi, 0x0d ori, 0x0f lui, 0x0a slti}: dest rt, src ALU.
  - op in {0x23 lw, 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu}: dest rt, src DM.
  - op 0x03 jal: dest 31, src PC+8.
  - op 0x01 with rt in {0x10 bltzal, 0x11 bgezal}: dest 31, src PC+8, only when `b_j_w`=1; else no write.
  - Anything else (stores, branches, mult/div, mthi/mtlo, j, jr, nop): no write.
- PC+8 computed as 32-bit wrap-around add on `pc_w`.
- Effective write: decoded dest ≠ 0 and decode says write and `reset`=1. Writes to $0 dropped; `fwd_we_w`=0, `fwd_addr_w`=0.
- `fwd_data_w` always shows the selected data; it is 0 when no source is selected.
- Reads: address 0 → 0. Address equal to `fwd_addr_w` while `fwd_we_w`=1 → `fwd_data_w` (bypass). Otherwise → stored register.
- `retired_cnt` increments by 1 each cycle `instr_w` ≠ 0. It wraps 32'hFFFF_FFFF → 0.

## Timing
- Register write commits at the rising edge. Visible from storage in the next cycle and via bypass in the same cycle. Read path is combinational.
- Forward outputs are combinational from the W inputs, with zero latency.
- Reset (`reset`=0 at edge): all 32 registers and `retired_cnt` cleared. No write and no count occur that edge, even if the W inputs hold a valid instruction.
- While `reset`=0, the combinational outputs still reflect the inputs. Reset mid-program discards the in-flight W write.
- Simultaneous read of the same register by `rs` and `rt` both receive bypass data.

## Test plan
- Reset, then reads of $1..$31 → all 0; `retired_cnt`=0.
- W = ori $5 (instr 32'h3405_1234), alu_w=32'h1234, rs_addr_d=5 in the same cycle → rs_data_d=32'h1234 via bypass. Next cycle with W=nop → still 32'h1234. `retired_cnt`=1.
- W = jal, pc_w=32'h0000_3010 → $31=32'h0000_3018. W = bgezal with b_j_w=0 → $31 unchanged, fwd_we_w=0. With b_j_w=1 and pc_w=32'h3020 → $31=32'h3028.
- W = addu with rd=0, alu_w=32'hDEAD_BEEF → $0 reads 0, fwd_we_w=0, fwd_addr_w=0.
- W = lw $7 with dm_w=32'hCAFE_F00D → $7 written. W = mflo $8 with md_w=32'h0000_0042 → $8=32'h42. W = sw → no register changes.
- Write $9=32'h55, then assert reset=0 for one edge while W = ori $9 with value 32'h77 → $9 reads 0 after reset and the write is lost. Also preload `retired_cnt` near wrap (drive 2^32 nonzero W cycles, or force) and check wrap to 0.
